// File: rtl/key_if_pkg.sv
// Shared definitions for the key-entry command interface.
// The unlock constants live here so the sender and the lock controller agree.
package key_if_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT,
    DONE
  } key_state_e;

  localparam int KEY_WORDS = 4;
  localparam int CMD_WIDTH = 5;
  localparam int MODE_BIT  = 4;
  localparam int GAP_WIDTH = 8;
  localparam int IDX_WIDTH = 3;

  typedef logic [CMD_WIDTH-1:0] cmd_word_t;

  localparam cmd_word_t KEY0 = 5'b00001;
  localparam cmd_word_t KEY1 = 5'b00000;
  localparam cmd_word_t KEY2 = 5'b00100;
  localparam cmd_word_t KEY3 = 5'b00000;

  // Registered view of everything the sender drives onto the bus.
  typedef struct packed {
    logic      valid;
    logic      busy;
    logic      done;
    cmd_word_t key;
  } cmd_out_t;

  function automatic cmd_word_t mode_word(input logic mode);
    cmd_word_t w;
    w           = '0;
    w[MODE_BIT] = mode;
    return w;
  endfunction

endpackage

// File: rtl/key_cmd_sender_if.sv
// Command bus between the host/sequencer, the key sender and the lock controller.
// master = the sender driving words; slave = the host/consumer side.
interface key_cmd_sender_if;
  import key_if_pkg::*;

  logic      Start;
  logic      ModeReq;
  logic      Abort;
  cmd_word_t InputKey;
  logic      ValidCmd;
  logic      Busy;
  logic      Done;

  modport master (
    input  Start,
    input  ModeReq,
    input  Abort,
    output InputKey,
    output ValidCmd,
    output Busy,
    output Done
  );

  modport slave (
    output Start,
    output ModeReq,
    output Abort,
    input  InputKey,
    input  ValidCmd,
    input  Busy,
    input  Done
  );

endinterface

// File: rtl/key_cmd_sender_gap_timer.sv
// Loadable down-counter that times the idle gap between command words.
// Counting stops at zero; zero is flagged combinationally.
module key_gap_timer #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/key_cmd_sender.sv
// Transmit side of the key-entry command interface: sends the four unlock words
// and one mode word per accepted Start, with an optional idle gap between words.
module key_cmd_sender #(
  parameter int unsigned          GAP  = 0,
  parameter key_if_pkg::cmd_word_t KEY0 = key_if_pkg::KEY0,
  parameter key_if_pkg::cmd_word_t KEY1 = key_if_pkg::KEY1,
  parameter key_if_pkg::cmd_word_t KEY2 = key_if_pkg::KEY2,
  parameter key_if_pkg::cmd_word_t KEY3 = key_if_pkg::KEY3
) (
  input logic               Clk,
  input logic               Reset,
  key_cmd_sender_if.master  bus
);
  import key_if_pkg::*;

  localparam logic [GAP_WIDTH-1:0] GAP_LOAD = GAP_WIDTH'(GAP);
  localparam logic [IDX_WIDTH-1:0] IDX_MODE = IDX_WIDTH'(KEY_WORDS);

  key_state_e           state, state_nxt;
  logic [IDX_WIDTH-1:0] idx, idx_nxt;
  logic                 mode_q, mode_nxt;
  logic                 gap_load, gap_dec, gap_zero, gap_last;
  logic [GAP_WIDTH-1:0] gap_count;
  cmd_out_t             out_q, out_nxt;

  key_gap_timer #(
    .WIDTH (GAP_WIDTH)
  ) u_gap_timer (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (gap_load),
    .load_val (GAP_LOAD),
    .dec      (gap_dec),
    .count    (gap_count),
    .zero     (gap_zero)
  );

  // A drained counter also releases WAIT so the FSM can never stall there.
  assign gap_last = (gap_count == GAP_WIDTH'(1)) || gap_zero;

  function automatic cmd_word_t word_at(input logic [IDX_WIDTH-1:0] i, input logic m);
    case (i)
      3'd0:    return KEY0;
      3'd1:    return KEY1;
      3'd2:    return KEY2;
      3'd3:    return KEY3;
      3'd4:    return mode_word(m);
      default: return '0;
    endcase
  endfunction

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state  <= IDLE;
      idx    <= '0;
      mode_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      mode_q <= mode_nxt;
    end
  end

  // NOTE: every signal assigned here gets a default first, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    mode_nxt  = mode_q;
    gap_load  = 1'b0;
    gap_dec   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.Start && !bus.Abort) begin
          state_nxt = SEND;
          idx_nxt   = '0;
          mode_nxt  = bus.ModeReq;
        end
      end
      SEND: begin
        if (bus.Abort || (idx > IDX_MODE)) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end else if (idx == IDX_MODE) begin
          state_nxt = DONE;
        end else if (GAP_LOAD != '0) begin
          state_nxt = WAIT;
          gap_load  = 1'b1;
        end else begin
          idx_nxt = idx + 3'd1;
        end
      end
      WAIT: begin
        gap_dec = 1'b1;
        if (bus.Abort) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end else if (gap_last) begin
          state_nxt = SEND;
          idx_nxt   = idx + 3'd1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up with the state.
  always_comb begin
    out_nxt       = '0;
    out_nxt.valid = (state_nxt == SEND);
    out_nxt.busy  = (state_nxt == SEND) || (state_nxt == WAIT);
    out_nxt.done  = (state_nxt == DONE);
    if (state_nxt == SEND) begin
      out_nxt.key = word_at(idx_nxt, mode_nxt);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      out_q <= '0;
    end else begin
      out_q <= out_nxt;
    end
  end

  assign bus.InputKey = out_q.key;
  assign bus.ValidCmd = out_q.valid;
  assign bus.Busy     = out_q.busy;
  assign bus.Done     = out_q.done;

endmodule

// File: tb/tb_key_cmd_sender.sv
// Directed bench for key_cmd_sender: three instances (GAP 0, GAP 2, corrupted KEY1)
// share one stimulus path selected by sel; a small lock-controller model checks end to end.
module tb_key_cmd_sender;
  import key_if_pkg::*;

  typedef logic [7:0] trace_t [1:16];

  logic       Clk;
  logic       Reset;
  logic [1:0] sel;
  logic       start_drv, mode_drv, abort_drv, lock_clr;
  int         n_cmp, n_err;

  key_cmd_sender_if if_g0 ();
  key_cmd_sender_if if_g2 ();
  key_cmd_sender_if if_bad ();

  key_cmd_sender #(.GAP(0)) u_g0 (.Clk(Clk), .Reset(Reset), .bus(if_g0));
  key_cmd_sender #(.GAP(2)) u_g2 (.Clk(Clk), .Reset(Reset), .bus(if_g2));
  key_cmd_sender #(.GAP(0), .KEY1(5'b00010)) u_bad (.Clk(Clk), .Reset(Reset), .bus(if_bad));

  assign if_g0.Start    = start_drv && (sel == 2'd0);
  assign if_g2.Start    = start_drv && (sel == 2'd1);
  assign if_bad.Start   = start_drv && (sel == 2'd2);
  assign if_g0.Abort    = abort_drv && (sel == 2'd0);
  assign if_g2.Abort    = abort_drv && (sel == 2'd1);
  assign if_bad.Abort   = abort_drv && (sel == 2'd2);
  assign if_g0.ModeReq  = mode_drv;
  assign if_g2.ModeReq  = mode_drv;
  assign if_bad.ModeReq = mode_drv;

  logic      o_valid, o_busy, o_done;
  cmd_word_t o_key;
  logic [7:0] o_pk;

  always_comb begin
    o_valid = if_g0.ValidCmd;
    o_busy  = if_g0.Busy;
    o_done  = if_g0.Done;
    o_key   = if_g0.InputKey;
    case (sel)
      2'd1: begin
        o_valid = if_g2.ValidCmd; o_busy = if_g2.Busy;
        o_done  = if_g2.Done;     o_key  = if_g2.InputKey;
      end
      2'd2: begin
        o_valid = if_bad.ValidCmd; o_busy = if_bad.Busy;
        o_done  = if_bad.Done;     o_key  = if_bad.InputKey;
      end
      default: ;
    endcase
  end

  assign o_pk = {o_valid, o_busy, o_done, o_key};

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Lock controller model: word i must carry the expected value in bit i.
  logic [2:0] lk_cnt;
  logic       lk_ok, lk_active, lk_mode;
  logic [3:0] lk_bits;
  assign lk_bits = 4'b0101;

  always @(posedge Clk or posedge Reset) begin
    if (Reset || lock_clr) begin
      lk_cnt <= '0; lk_ok <= 1'b1; lk_active <= 1'b0; lk_mode <= 1'b0;
    end else if (o_valid) begin
      if (lk_cnt < 3'd4) begin
        if (o_key[lk_cnt[1:0]] != lk_bits[lk_cnt[1:0]]) lk_ok <= 1'b0;
        lk_cnt <= lk_cnt + 3'd1;
      end else if (lk_cnt == 3'd4) begin
        lk_active <= lk_ok;
        lk_mode   <= lk_ok & o_key[MODE_BIT];
        lk_cnt    <= 3'd5;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] rec [1:16];

  // Start is driven in the cycle before edge N; rec[c] holds cycle N+c.
  // abort_at == 0 raises Abort together with Start.
  task automatic capture(input int k, input int restart_at, input int abort_at, input logic mode0);
    @(negedge Clk);
    start_drv = 1'b1;
    abort_drv = (abort_at == 0);
    mode_drv  = mode0;
    for (int c = 1; c <= k; c++) begin
      @(negedge Clk);
      rec[c]    = o_pk;
      start_drv = (c == restart_at);
      abort_drv = (c == abort_at);
      if (c == restart_at) mode_drv = ~mode0;
    end
    start_drv = 1'b0;
    abort_drv = 1'b0;
  endtask

  task automatic compare_trace(input string tag, input int n, input trace_t e);
    for (int c = 1; c <= n; c++) check($sformatf("%s c%0d", tag, c), {24'd0, rec[c]}, {24'd0, e[c]});
  endtask

  trace_t e_g0_m1   = '{8'hC1, 8'hC0, 8'hC4, 8'hC0, 8'hD0, 8'h20, 8'h00, 8'h00,
                        8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  trace_t e_g2_m0   = '{8'hC1, 8'h40, 8'h40, 8'hC0, 8'h40, 8'h40, 8'hC4, 8'h40,
                        8'h40, 8'hC0, 8'h40, 8'h40, 8'hC0, 8'h20, 8'h00, 8'h00};
  trace_t e_g2_m1   = '{8'hC1, 8'h40, 8'h40, 8'hC0, 8'h40, 8'h40, 8'hC4, 8'h40,
                        8'h40, 8'hC0, 8'h40, 8'h40, 8'hD0, 8'h20, 8'h00, 8'h00};
  trace_t e_abort   = '{8'hC1, 8'hC0, 8'hC4, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                        8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  trace_t e_g0_m0   = '{8'hC1, 8'hC0, 8'hC4, 8'hC0, 8'hC0, 8'h20, 8'h00, 8'h00,
                        8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  trace_t e_bad_m1  = '{8'hC1, 8'hC2, 8'hC4, 8'hC0, 8'hD0, 8'h20, 8'h00, 8'h00,
                        8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  trace_t e_zero    = '{default: 8'h00};

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_v, n_d;
    n_cmp = 0; n_err = 0;
    Reset = 1'b1; sel = 2'd0;
    start_drv = 1'b0; mode_drv = 1'b0; abort_drv = 1'b0; lock_clr = 1'b0;
    repeat (3) @(negedge Clk);
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      check($sformatf("reset outputs dut%0d", s), {24'd0, o_pk}, 32'd0);
    end
    @(negedge Clk);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);

    // GAP 0, mode 1: five back-to-back words then Done
    sel = 2'd0;
    capture(8, -1, -1, 1'b1);
    compare_trace("g0 mode1", 8, e_g0_m1);

    // GAP 2, mode 0: words every third cycle
    sel = 2'd1;
    capture(16, -1, -1, 1'b0);
    compare_trace("g2 mode0", 16, e_g2_m0);

    // Start re-pulsed while busy with ModeReq toggled: ignored
    capture(16, 3, -1, 1'b1);
    compare_trace("g2 restart", 16, e_g2_m1);
    n_v = 0; n_d = 0;
    for (int c = 1; c <= 16; c++) begin
      n_v += int'(rec[c][7]);
      n_d += int'(rec[c][5]);
    end
    check("restart valid pulses", n_v, 5);
    check("restart done pulses", n_d, 1);

    // Abort while the third word is on the bus, then a fresh sequence
    sel = 2'd0;
    capture(6, -1, 3, 1'b1);
    compare_trace("abort", 6, e_abort);
    capture(8, -1, -1, 1'b0);
    compare_trace("after abort", 8, e_g0_m0);

    // Start and Abort together in IDLE: nothing starts
    capture(4, -1, 0, 1'b1);
    compare_trace("start+abort", 4, e_zero);

    // Asynchronous reset in the middle of a WAIT
    sel = 2'd1;
    capture(5, -1, -1, 1'b1);
    check("pre-reset wait", {24'd0, rec[5]}, 32'h40);
    Reset = 1'b1;
    #1;
    check("async reset outputs", {24'd0, o_pk}, 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    n_v = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge Clk);
      n_v += int'(o_valid);
    end
    check("quiet after reset", n_v, 0);

    // End to end against the lock controller model
    sel = 2'd0;
    @(negedge Clk); lock_clr = 1'b1;
    @(negedge Clk); lock_clr = 1'b0;
    capture(8, -1, -1, 1'b1);
    compare_trace("e2e good", 8, e_g0_m1);
    check("lock active good", {31'd0, lk_active}, 32'd1);
    check("lock mode good", {31'd0, lk_mode}, 32'd1);

    sel = 2'd2;
    @(negedge Clk); lock_clr = 1'b1;
    @(negedge Clk); lock_clr = 1'b0;
    capture(8, -1, -1, 1'b1);
    compare_trace("e2e bad key", 8, e_bad_m1);
    check("lock active bad", {31'd0, lk_active}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
